// File: rtl/hazard_seq_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard sequencer.
package hazard_seq_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int XZR_DEFAULT = 31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/hseq_raw_cmp.sv
// Single RAW comparator: an ID source read against one older destination write.
module hseq_raw_cmp
    import hazard_seq_pkg::*;
#(
    parameter int XZR_IDX = XZR_DEFAULT
) (
    input  logic [REG_IDX_W-1:0] src,
    input  logic                 src_used,
    input  logic [REG_IDX_W-1:0] dst,
    input  logic                 dst_writes,
    output logic                 match
);

    assign match = src_used && dst_writes && (src == dst)
                && (src != REG_IDX_W'(XZR_IDX));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: RAW stalls, taken-branch flushes, HALT drain/resume, event counters.
// Define HAZARD_SEQ_FULL_INTERLOCK_EN for a datapath without forwarding (stall on any EX/MEM RAW).
module hazard_sequencer
    import hazard_seq_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int XZR_IDX      = XZR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rn,
    input  logic [REG_IDX_W-1:0] id_rm,
    input  logic                 id_uses_rm,
    input  logic                 id_halt,
    input  logic                 idex_memread,
    input  logic                 idex_regwrite,
    input  logic [REG_IDX_W-1:0] idex_write_reg,
    input  logic                 exmem_regwrite,
    input  logic [REG_IDX_W-1:0] exmem_write_reg,
    input  logic                 exmem_branch_taken,
    input  logic                 resume,
    output logic                 pc_write_en,
    output logic                 ifid_write_en,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 exmem_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t         state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic               stall_inc, flush_inc;
    logic               idex_hz_writes;
    logic               rn_ex_hit, rm_ex_hit;
    logic               hz;

    hseq_raw_cmp #(.XZR_IDX(XZR_IDX)) u_cmp_rn_ex (
        .src(id_rn), .src_used(1'b1), .dst(idex_write_reg),
        .dst_writes(idex_hz_writes), .match(rn_ex_hit)
    );
    hseq_raw_cmp #(.XZR_IDX(XZR_IDX)) u_cmp_rm_ex (
        .src(id_rm), .src_used(id_uses_rm), .dst(idex_write_reg),
        .dst_writes(idex_hz_writes), .match(rm_ex_hit)
    );

`ifdef HAZARD_SEQ_FULL_INTERLOCK_EN
    logic rn_mem_hit, rm_mem_hit;

    // A load also writes its destination, so the EX check covers load-use too.
    assign idex_hz_writes = idex_memread | idex_regwrite;

    hseq_raw_cmp #(.XZR_IDX(XZR_IDX)) u_cmp_rn_mem (
        .src(id_rn), .src_used(1'b1), .dst(exmem_write_reg),
        .dst_writes(exmem_regwrite), .match(rn_mem_hit)
    );
    hseq_raw_cmp #(.XZR_IDX(XZR_IDX)) u_cmp_rm_mem (
        .src(id_rm), .src_used(id_uses_rm), .dst(exmem_write_reg),
        .dst_writes(exmem_regwrite), .match(rm_mem_hit)
    );

    assign hz = rn_ex_hit | rm_ex_hit | rn_mem_hit | rm_mem_hit;
`else
    logic unused_fwd_inputs;

    assign idex_hz_writes    = idex_memread;
    assign unused_fwd_inputs = ^{idex_regwrite, exmem_regwrite, exmem_write_reg};
    assign hz                = rn_ex_hit | rm_ex_hit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (stall_inc) stall_count <= stall_count + CNT_W'(1);
            if (flush_inc) flush_count <= flush_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_nxt     = drain_cnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        halted        = 1'b0;

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (exmem_branch_taken) begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_bubble   = 1'b1;
                        exmem_flush   = 1'b1;
                        flush_inc     = 1'b1;
                    end else if (hz) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (id_halt) begin
                        idex_bubble = 1'b1;
                        drain_nxt   = DRAIN_W'(DRAIN_CYCLES - 1);
                        state_nxt   = DRAIN;
                    end else begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                    end
                end
                DRAIN: begin
                    // An older taken branch cancels the HALT still sitting in IFID.
                    if (exmem_branch_taken) begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_bubble   = 1'b1;
                        exmem_flush   = 1'b1;
                        flush_inc     = 1'b1;
                        state_nxt     = RUN;
                    end else begin
                        idex_bubble = 1'b1;
                        if (drain_cnt == '0) state_nxt = HALTED;
                        else                 drain_nxt = drain_cnt - DRAIN_W'(1);
                    end
                end
                HALTED: begin
                    halted      = 1'b1;
                    idex_bubble = 1'b1;
                    if (resume) begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        ifid_flush    = 1'b1;
                        state_nxt     = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

endmodule
